// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_pkg
// Purpose  : Shared constants and elaboration helpers for the pipelined
//            add/subtract unit.
// Contents : C_MIN_SEG       - smallest legal segment width in bits
//            split_is_legal  - true when WIDTH splits evenly into LEVEL
//                              non-empty segments
// Revision : 1.0 - initial release
// ============================================================================
package pipe_adder_pkg;

    localparam int C_MIN_SEG = 1;

    function automatic bit split_is_legal(input int width, input int level);
        return (level > 0) && (width >= level) && ((width % level) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_seg.sv
`default_nettype none
// ============================================================================
// Module   : adder_seg
// Purpose  : Combinational SEG-bit ripple-carry segment. Used as one pipeline
//            stage of pipe_adder.
// Ports    : a_seg  in  SEG  operand A slice
//            b_seg  in  SEG  operand B slice (already inverted in sub mode)
//            c_in   in  1    carry into the segment LSB
//            s_seg  out SEG  sum slice
//            c_out  out 1    carry out of the segment MSB
//            c_msb  out 1    carry into the segment MSB (overflow detection)
// Revision : 1.0 - initial release
// ============================================================================
module adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           c_in,
    output logic [SEG-1:0] s_seg,
    output logic           c_out,
    output logic           c_msb
);

    generate
        if (SEG < C_MIN_SEG) begin : g_bad_seg
            $error("adder_seg: SEG must be at least %0d", C_MIN_SEG);
        end
    endgenerate

    // w_carry[i] is the carry into bit i; w_carry[SEG] leaves the segment.
    logic [SEG:0] w_carry;

    // The ripple is built inside one process so the chain is evaluated in a
    // single ordered pass.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            w_carry[i+1] = (a_seg[i] & b_seg[i]) | ((a_seg[i] ^ b_seg[i]) & w_carry[i]);
        end
    end

    assign s_seg = a_seg ^ b_seg ^ w_carry[SEG-1:0];
    assign c_out = w_carry[SEG];
    assign c_msb = w_carry[SEG-1];

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Purpose  : Pipelined WIDTH-bit add/subtract unit. The carry chain is cut
//            into LEVEL registered segments of SEG = WIDTH/LEVEL bits, one
//            segment resolved per stage, with a valid/ready stream interface.
// Ports    : clk        in  1      clock, rising edge
//            rst_n      in  1      asynchronous active-low reset
//            in_valid   in  1      operand set valid
//            in_ready   out 1      operand set accepted this cycle if valid
//            a, b       in  WIDTH  operands
//            cin        in  1      carry-in (add) / borrow-in (sub)
//            sub        in  1      0: a+b+cin   1: a-b-cin
//            out_valid  out 1      result valid
//            out_ready  in  1      downstream accepts result
//            s          out WIDTH  sum / difference
//            cout       out 1      carry-out; in sub mode 1 = no borrow
//            ovf        out 1      two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / LEVEL;

    generate
        if (!split_is_legal(WIDTH, LEVEL)) begin : g_bad_split
            $error("pipe_adder: WIDTH (%0d) must be divisible by LEVEL (%0d)", WIDTH, LEVEL);
        end
    endgenerate

    // Segment adder inputs/outputs, one entry per stage.
    logic [SEG-1:0] w_seg_a  [LEVEL];
    logic [SEG-1:0] w_seg_b  [LEVEL];
    logic [SEG-1:0] w_seg_s  [LEVEL];
    logic           w_seg_ci [LEVEL];
    logic           w_seg_co [LEVEL];
    logic           w_seg_cm [LEVEL];
    logic           w_en;

    // Pipeline registers written at the end of stage k. Operands and the
    // sub bit travel full width so later stages pick their own slice;
    // r_s accumulates the resolved low slices so the whole result exits
    // together.
    logic             r_v   [LEVEL];
    logic [WIDTH-1:0] r_a   [LEVEL];
    logic [WIDTH-1:0] r_b   [LEVEL];
    logic [WIDTH-1:0] r_s   [LEVEL];
    logic             r_sub [LEVEL];
    logic             r_c   [LEVEL];
    logic             r_ovf;

    // Whole pipeline moves in lockstep; it only freezes when the output
    // holds a result that nobody is taking.
    assign w_en      = !r_v[LEVEL-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v[LEVEL-1];
    assign s         = r_s[LEVEL-1];
    assign cout      = r_c[LEVEL-1];
    assign ovf       = r_ovf;

    genvar k;
    generate
        for (k = 0; k < LEVEL; k++) begin : g_stage
            if (k == 0) begin : g_first
                // Subtraction is a + ~b + ~cin, so the borrow-in becomes an
                // inverted carry-in.
                assign w_seg_a[k]  = a[SEG-1:0];
                assign w_seg_b[k]  = b[SEG-1:0] ^ {SEG{sub}};
                assign w_seg_ci[k] = cin ^ sub;
            end else begin : g_rest
                assign w_seg_a[k]  = r_a[k-1][k*SEG +: SEG];
                assign w_seg_b[k]  = r_b[k-1][k*SEG +: SEG] ^ {SEG{r_sub[k-1]}};
                assign w_seg_ci[k] = r_c[k-1];
            end

            adder_seg #(
                .SEG   (SEG)
            ) u_seg (
                .a_seg (w_seg_a[k]),
                .b_seg (w_seg_b[k]),
                .c_in  (w_seg_ci[k]),
                .s_seg (w_seg_s[k]),
                .c_out (w_seg_co[k]),
                .c_msb (w_seg_cm[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEVEL; i++) begin
                r_v[i]   <= 1'b0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_s[i]   <= '0;
                r_sub[i] <= 1'b0;
                r_c[i]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            // A bubble (in_valid=0) still advances; only its valid bit is 0.
            r_v[0]          <= in_valid;
            r_a[0]          <= a;
            r_b[0]          <= b;
            r_sub[0]        <= sub;
            r_c[0]          <= w_seg_co[0];
            r_s[0]          <= '0;
            r_s[0][SEG-1:0] <= w_seg_s[0];
            for (int i = 1; i < LEVEL; i++) begin
                r_v[i]               <= r_v[i-1];
                r_a[i]               <= r_a[i-1];
                r_b[i]               <= r_b[i-1];
                r_sub[i]             <= r_sub[i-1];
                r_c[i]               <= w_seg_co[i];
                r_s[i]               <= r_s[i-1];
                r_s[i][i*SEG +: SEG] <= w_seg_s[i];
            end
            // Signed overflow: carry into MSB differs from carry out of MSB.
            r_ovf <= w_seg_cm[LEVEL-1] ^ w_seg_co[LEVEL-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Purpose  : Self-checking bench for pipe_adder (WIDTH=8, LEVEL=2).
//            Directed vectors push expected results into a scoreboard queue;
//            a monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    localparam int WIDTH = 8;
    localparam int LEVEL = 2;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    int   last_acc = 0;
    bit   rand_rdy = 1'b0;
    bit   stall    = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pipe_adder #(
        .WIDTH     (WIDTH),
        .LEVEL     (LEVEL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent reference: plain integer arithmetic.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, input logic su);
        exp_t       e;
        logic [8:0] t;
        if (!su) begin
            t   = x + y + ci;
            e.s = t[7:0];
            e.c = t[8];
            e.o = (x[7] == y[7]) && (e.s[7] != x[7]);
        end else begin
            e.s = x - y - ci;
            e.c = ({1'b0, x} >= ({1'b0, y} + 9'(ci)));
            e.o = (x[7] != y[7]) && (e.s[7] != x[7]);
        end
        return e;
    endfunction

    // Downstream ready: always, random, or forced low.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = stall ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: a transfer happens at the next rising edge when both are high.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got s=%0h with no pending op (t=%0t)", s, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("s",    32'(s),    32'(mon_e.s));
                    chk("cout", 32'(cout), 32'(mon_e.c));
                    chk("ovf",  32'(ovf),  32'(mon_e.o));
                end
            end
        end
    end

    // Must be called at a falling edge; returns at the falling edge after
    // the accepting rising edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic isub, input exp_t e);
        int w;
        w        = 0;
        a        = ia;
        b        = ib;
        cin      = ic;
        sub      = isub;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            w++;
            if (w > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
                in_valid = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            #1;
        end
        sb.push_back(e);
        last_acc = cyc;
        n_acc++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out_latency(input string name);
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(name, 32'(cyc - last_acc), 32'(LEVEL));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic exp_t mk(input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        e.s = es;
        e.c = ec;
        e.o = eo;
        return e;
    endfunction

    // Backpressure stream vectors: {a, b, cin, sub} and hand-computed results.
    logic [7:0] bp_a [6] = '{8'h01, 8'h10, 8'h33, 8'h80, 8'h20, 8'h00};
    logic [7:0] bp_b [6] = '{8'h02, 8'hF0, 8'h44, 8'h80, 8'h01, 8'h01};
    logic       bp_sb[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] bp_s [6] = '{8'h03, 8'h00, 8'h77, 8'h00, 8'h1F, 8'hFF};
    logic       bp_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       bp_o [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [7:0] held_s;
        logic       held_c;
        logic       held_o;
        int         base;
        int         w;
        logic [16:0] v;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s",         32'(s),         32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry across the segment boundary, with latency check
        issue(8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0));
        wait_out_latency("latency_add");
        issue(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0));
        issue(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, mk(8'hFF, 1'b1, 1'b0));
        issue(8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0));
        issue(8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1));
        issue(8'h10, 8'h00, 1'b1, 1'b1, mk(8'h0F, 1'b1, 1'b0));
        issue(8'h00, 8'h00, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0));
        drain();

        // Backpressure: 6 back-to-back ops, 3-cycle stall mid-stream
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    issue(bp_a[i], bp_b[i], 1'b0, bp_sb[i], mk(bp_s[i], bp_c[i], bp_o[i]));
                end
            end
            begin
                w = 0;
                while (n_acc < base + 3 && w < 100) begin
                    @(posedge clk);
                    w++;
                end
                #1;
                stall = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    #2;
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_in_ready",  32'(in_ready),  32'd0);
                    if (j == 0) begin
                        held_s = s;
                        held_c = cout;
                        held_o = ovf;
                    end else begin
                        chk("stall_hold_s",    32'(s),    32'(held_s));
                        chk("stall_hold_cout", 32'(cout), 32'(held_c));
                        chk("stall_hold_ovf",  32'(ovf),  32'(held_o));
                    end
                end
                stall = 1'b0;
            end
        join
        drain();

        // Asynchronous reset with operations in flight
        @(negedge clk);
        stall = 1'b1;
        issue(8'h12, 8'h34, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0));
        issue(8'hF0, 8'h0F, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0));
        #3;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_s",         32'(s),         32'd0);
        chk("async_rst_cout",      32'(cout),      32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h3C, 8'h0C, 1'b0, 1'b0, mk(8'h48, 1'b0, 1'b0));
        wait_out_latency("latency_after_reset");
        drain();
        repeat (4) @(negedge clk);

        // Sweep both modes with random downstream ready
        rand_rdy = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < (1 << 17); i += 101) begin
                v = 17'(i);
                issue(v[16:9], v[8:1], v[0], 1'(m), model(v[16:9], v[8:1], v[0], 1'(m)));
            end
        end
        drain();
        rand_rdy = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit, the successor to the combinational parametrised full adder.
- Splits a WIDTH-bit carry chain into LEVEL registered segments, so the carry path per cycle is only WIDTH/LEVEL bits.
- Adds a subtract mode, a signed-overflow flag and a valid/ready stream handshake.
- Sits in arithmetic datapaths that need full-rate adds at higher clock frequency.

Parameters:
- WIDTH, 8, operand/result width in bits.
- LEVEL, 2, number of pipeline segments and stages; WIDTH must be divisible by LEVEL; LEVEL=1 gives a single registered adder.
- SEG (localparam), WIDTH/LEVEL, bits per segment.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand set valid
- in_ready  out  1  unit can accept an operand set this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = a+b+cin, 1 = a-b-cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- cout  out  1  carry-out; in sub mode 1 = no borrow
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Arithmetic:
  - Add: {cout,s} = a + b + cin.
  - Sub: computed as a + ~b + ~cin, so the result is a - b - cin mod 2^WIDTH, and cout = NOT borrow.
  - ovf = carry into MSB XOR carry out of MSB, in both modes.
- Pipeline structure:
  - Stage k (k=0..LEVEL-1) computes segment bits [k*SEG +: SEG] using the carry registered from stage k-1. Stage 0 uses cin, inverted when sub=1.
  - Upper operand slices and the sub bit are skewed through delay registers.
  - Lower result slices are carried forward so all bits of one operation leave together.
- Latency: exactly LEVEL cycles from the accepting edge to out_valid, with no stall.
- Throughput: one operation per cycle.
- Handshake:
  - Global enable en = !out_valid | out_ready; all pipeline registers advance only when en=1.
  - in_ready = en (combinational); an input is accepted on an edge where in_valid & in_ready.
  - A per-stage valid bit moves with the data. Bubbles are not compressed; they advance with the pipeline.
  - While out_valid=1 and out_ready=0: s, cout and ovf hold stable and in_ready=0.
  - in_valid=0 while en=1 injects a bubble; out_valid drops when that bubble reaches the output.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Reset:
  - Asserting rst_n=0 immediately clears all valid bits and sets s=0, cout=0, ovf=0, independent of clk.
  - Operations in flight at reset are discarded.
  - in_ready=1 during and after reset, since out_valid=0.
- Boundaries:
  - a=b=all-ones with cin=1 gives s=all-ones, cout=1.
  - Carry or borrow crossing every segment boundary must be exact.
  - WIDTH%LEVEL != 0 must fail elaboration through a generate-time error.
- Inputs are not sampled when in_ready=0; a, b, cin and sub are don't-care when in_valid=0.

Decomposition:
- Shared package/include: no typedefs needed. SEG and the WIDTH%LEVEL legality check are local.
- Sub-module adder_seg: combinational SEG-bit ripple segment.
  - Ports: a_seg, b_seg (already inverted for sub), c_in, s_seg, c_out, c_msb (carry into the segment MSB, used for ovf in the top segment).
- pipe_adder instantiates LEVEL adder_seg instances through generate and owns all registers and handshake logic.

Test Plan (WIDTH=8, LEVEL=2 unless noted):
1. Add 8'h0F + 8'h01, cin=0, sub=0, out_ready=1 -> out_valid exactly 2 cycles later with s=8'h10, cout=0, ovf=0 (carry crosses the segment boundary). Also 8'hFF + 8'h01 -> s=8'h00, cout=1, ovf=0.
2. Add 8'h7F + 8'h01 -> s=8'h80, cout=0, ovf=1. Add 8'hFF + 8'hFF, cin=1 -> s=8'hFF, cout=1, ovf=0.
3. Sub, sub=1: 8'h05 - 8'h07, cin=0 -> s=8'hFE, cout=0, ovf=0. 8'h80 - 8'h01 -> s=8'h7F, cout=1, ovf=1. 8'h10 - 8'h00, cin=1 -> s=8'h0F, cout=1.
4. Backpressure: stream 6 back-to-back ops and hold out_ready=0 for 3 cycles mid-stream.
   - in_ready=0 during the stall; s, cout and ovf hold.
   - All 6 results are delivered in order with none lost or duplicated.
5. Reset mid-operation: accept 2 ops, assert rst_n between clock edges.
   - out_valid=0 and s=0 immediately, with no clock edge.
   - After release, a new op appears after exactly 2 cycles and no stale result is emitted.
6. Sweep: {a,b,cin} = i for i stepping by 101 over 0..2^17-1 in both modes, with random out_ready.
   - Every output matches the reference model.
   - Repeat with LEVEL=1, 4 and 8, and with WIDTH=16, LEVEL=4.
